// File: rtl/alu_issue_stage.sv
// alu_issue_stage: EX-stage decode/issue to an external ALU with EX/MEM result register and branch resolve
module alu_issue_stage (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic        flush,
    output logic [5:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_br_taken,
    output logic        out_illegal
);
    localparam logic [5:0] C_ADD = 6'b100000;
    localparam logic [5:0] C_SUB = 6'b100010;
    localparam logic [5:0] C_MUL = 6'b011000;
    localparam logic [5:0] C_AND = 6'b100100;
    localparam logic [5:0] C_OR  = 6'b100101;
    localparam logic [5:0] C_XOR = 6'b100110;
    localparam logic [3:0] K_NONE = 4'd0;
    localparam logic [3:0] K_SLT  = 4'd1;
    localparam logic [3:0] K_BEQ  = 4'd2;
    localparam logic [3:0] K_BNE  = 4'd3;
    localparam logic [3:0] K_BLTZ = 4'd4;
    localparam logic [3:0] K_BGEZ = 4'd5;
    localparam logic [3:0] K_BGTZ = 4'd6;
    localparam logic [3:0] K_BLEZ = 4'd7;
    localparam logic [3:0] K_ILL  = 4'd8;
    logic        ex_valid_q, ex_valid_d, out_valid_q, out_valid_d;
    logic [5:0]  ctl_q, ctl_d, dec_ctl;
    logic [31:0] a_q, a_d, b_q, b_d, dec_a, dec_b;
    logic [4:0]  rd_q, rd_d, out_rd_q, out_rd_d;
    logic [3:0]  kind_q, kind_d, dec_kind;
    logic [31:0] out_result_q, out_result_d, res_fix;
    logic        out_br_q, out_br_d, out_ill_q, out_ill_d;
    logic        ex_adv, accept, move, ovf, br;
    logic [31:0] sext, zext;
    assign sext = {{16{in_imm[15]}}, in_imm};
    assign zext = {16'b0, in_imm};
    always_comb begin
        dec_ctl  = C_ADD;
        dec_a    = in_rs_val;
        dec_b    = sext;
        dec_kind = K_NONE;
        case (in_opcode)
            6'b000000: case (in_funct)
                6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b100110: begin
                    dec_ctl = in_funct;
                    dec_b   = in_rt_val;
                end
                6'b101010: begin
                    dec_ctl  = C_SUB;
                    dec_b    = in_rt_val;
                    dec_kind = K_SLT;
                end
                6'b000000, 6'b000010: begin
                    dec_ctl = in_funct;
                    dec_a   = in_rt_val;
                    dec_b   = {27'b0, in_shamt};
                end
                default: dec_kind = K_ILL;
            endcase
            6'b011100: begin
                dec_ctl  = C_MUL;
                dec_b    = in_rt_val;
                dec_kind = (in_funct == 6'b000010) ? K_NONE : K_ILL;
            end
            6'b001000, 6'b100011, 6'b101011, 6'b100000, 6'b100001, 6'b101000, 6'b101001: dec_ctl = C_ADD;
            6'b001010: begin
                dec_ctl  = C_SUB;
                dec_kind = K_SLT;
            end
            6'b001100: begin
                dec_ctl = C_AND;
                dec_b   = zext;
            end
            6'b001101: begin
                dec_ctl = C_OR;
                dec_b   = zext;
            end
            6'b001110: begin
                dec_ctl = C_XOR;
                dec_b   = zext;
            end
            6'b000100, 6'b000101: begin
                dec_ctl  = C_SUB;
                dec_b    = in_rt_val;
                dec_kind = in_opcode[0] ? K_BNE : K_BEQ;
            end
            6'b000110, 6'b000111: begin
                dec_ctl  = C_SUB;
                dec_b    = '0;
                dec_kind = in_opcode[0] ? K_BGTZ : K_BLEZ;
            end
            6'b000001: begin
                dec_ctl  = C_SUB;
                dec_b    = '0;
                dec_kind = (in_rt == 5'd0) ? K_BLTZ : (in_rt == 5'd1) ? K_BGEZ : K_ILL;
            end
            default: dec_kind = K_ILL;
        endcase
        if (dec_kind == K_ILL) begin
            dec_ctl = C_ADD;
            dec_a   = '0;
            dec_b   = '0;
        end
    end
    always_comb begin
        ex_adv   = ex_valid_q & (~out_valid_q | out_ready);
        in_ready = ~ex_valid_q | ex_adv;
        accept   = in_valid & in_ready & ~flush;
        move     = ex_adv & ~flush;
        ovf      = (a_q[31] != b_q[31]) & (alu_result[31] != a_q[31]);
        res_fix  = (kind_q == K_SLT) ? {31'b0, alu_result[31] ^ ovf} : alu_result;
        br       = (kind_q == K_BEQ  &  alu_zero) |
                   (kind_q == K_BNE  & ~alu_zero) |
                   (kind_q == K_BLTZ &  alu_result[31]) |
                   (kind_q == K_BGEZ & ~alu_result[31]) |
                   (kind_q == K_BGTZ & ~alu_result[31] & ~alu_zero) |
                   (kind_q == K_BLEZ & (alu_result[31] | alu_zero));
        ex_valid_d   = accept | (ex_valid_q & ~ex_adv & ~flush);
        ctl_d        = accept ? dec_ctl : ctl_q;
        a_d          = accept ? dec_a : a_q;
        b_d          = accept ? dec_b : b_q;
        rd_d         = accept ? in_rd : rd_q;
        kind_d       = accept ? dec_kind : kind_q;
        out_valid_d  = move | (out_valid_q & ~out_ready);
        out_result_d = move ? res_fix : out_result_q;
        out_rd_d     = move ? rd_q : out_rd_q;
        out_br_d     = move ? br : out_br_q;
        out_ill_d    = move ? (kind_q == K_ILL) : out_ill_q;
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_valid_q   <= 1'b0;
            ctl_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rd_q         <= '0;
            kind_q       <= K_NONE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_br_q     <= 1'b0;
            out_ill_q    <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ctl_q        <= ctl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rd_q         <= rd_d;
            kind_q       <= kind_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_br_q     <= out_br_d;
            out_ill_q    <= out_ill_d;
        end
    end
    assign alu_ctl      = ctl_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_rd       = out_rd_q;
    assign out_br_taken = out_br_q;
    assign out_illegal  = out_ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench with behavioural scoreboard for alu_issue_stage
module tb_alu_issue_stage;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [5:0]  in_opcode = '0, in_funct = '0, alu_ctl;
    logic [4:0]  in_rt = '0, in_rd = '0, in_shamt = '0, out_rd;
    logic [15:0] in_imm = '0;
    logic [31:0] in_rs_val = '0, in_rt_val = '0, alu_a, alu_b, alu_result, out_result;
    logic        alu_zero, out_br_taken, out_illegal;
    int n_chk = 0, n_fail = 0;
    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        br;
        logic        ill;
    } exp_t;
    exp_t q[$];
    logic occ_out = 1'b0;
    int   ex_occ;
    logic exp_rdy, blocked;
    logic [5:0]  bop [4] = '{6'd7, 6'd6, 6'd1, 6'd1};
    logic [4:0]  brt [4] = '{5'd0, 5'd0, 5'd0, 5'd1};
    logic [2:0]  tk  [4] = '{3'b010, 3'b101, 3'b001, 3'b110};
    logic [31:0] rsv [3] = '{32'h0, 32'h1, 32'hFFFFFFFF};
    always #5 Clk = ~Clk;
    alu_issue_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .flush(flush), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_br_taken(out_br_taken), .out_illegal(out_illegal)
    );
    always_comb begin
        case (alu_ctl)
            6'b100000: alu_result = alu_a + alu_b;
            6'b100010: alu_result = alu_a - alu_b;
            6'b011000: alu_result = alu_a * alu_b;
            6'b100100: alu_result = alu_a & alu_b;
            6'b100101: alu_result = alu_a | alu_b;
            6'b100111: alu_result = ~(alu_a | alu_b);
            6'b100110: alu_result = alu_a ^ alu_b;
            6'b000000: alu_result = alu_a << alu_b[4:0];
            6'b000010: alu_result = alu_a >> alu_b[4:0];
            default:   alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] se, ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'b0, imm};
        e.res = '0; e.rd = rd; e.br = 1'b0; e.ill = 1'b0;
        case (op)
            6'd0: case (fn)
                6'd32: e.res = a + b;
                6'd34: e.res = a - b;
                6'd36: e.res = a & b;
                6'd37: e.res = a | b;
                6'd39: e.res = ~(a | b);
                6'd38: e.res = a ^ b;
                6'd42: e.res = {31'b0, $signed(a) < $signed(b)};
                6'd0:  e.res = b << sh;
                6'd2:  e.res = b >> sh;
                default: e.ill = 1'b1;
            endcase
            6'd28: if (fn == 6'd2) e.res = a * b; else e.ill = 1'b1;
            6'd8, 6'd35, 6'd43, 6'd32, 6'd33, 6'd40, 6'd41: e.res = a + se;
            6'd10: e.res = {31'b0, $signed(a) < $signed(se)};
            6'd12: e.res = a & ze;
            6'd13: e.res = a | ze;
            6'd14: e.res = a ^ ze;
            6'd4: begin e.res = a - b; e.br = (a == b); end
            6'd5: begin e.res = a - b; e.br = (a != b); end
            6'd6: begin e.res = a; e.br = ($signed(a) <= 0); end
            6'd7: begin e.res = a; e.br = ($signed(a) > 0); end
            6'd1: begin
                e.res = a;
                if (rt == 5'd0) e.br = ($signed(a) < 0);
                else if (rt == 5'd1) e.br = ($signed(a) >= 0);
                else begin e.res = '0; e.ill = 1'b1; end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction
    always @(negedge Clk) begin
        if (!Rst_n) begin
            check("rst_outputs", {out_valid, out_br_taken, out_illegal, out_rd, alu_ctl}, 32'd0);
            check("rst_data", out_result | alu_a | alu_b, 32'd0);
            check("rst_in_ready", in_ready, 1);
            q.delete();
            occ_out = 1'b0;
        end else begin
            ex_occ  = q.size() - int'(occ_out);
            blocked = occ_out & ~out_ready;
            exp_rdy = !(ex_occ > 0 && blocked);
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, occ_out);
            if (occ_out && q.size() > 0) begin
                check("out_result", out_result, q[0].res);
                check("out_rd", out_rd, q[0].rd);
                check("out_br_taken", out_br_taken, q[0].br);
                check("out_illegal", out_illegal, q[0].ill);
            end
            if (flush && ex_occ > 0) begin
                void'(q.pop_back());
                ex_occ = 0;
            end
            if (occ_out && out_ready) begin
                void'(q.pop_front());
                occ_out = 1'b0;
            end
            if (ex_occ > 0 && !blocked) occ_out = 1'b1;
            if (in_valid && exp_rdy && !flush)
                q.push_back(model(in_opcode, in_funct, in_rt, in_rd, in_shamt, in_imm, in_rs_val, in_rt_val));
        end
    end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        in_opcode = op; in_funct = fn; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_rs_val = a; in_rt_val = b; in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge Clk);
            done = in_ready;
            @(posedge Clk);
            #2;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: actual=no_accept required=accept op=%b", op);
        end
        in_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "timeout");
    end
    initial begin
        Rst_n = 1'b1;
        #1 Rst_n = 1'b0;
        #2 check("reset_in_ready", in_ready, 1);
        check("reset_alu_ctl", alu_ctl, 0);
        step(2);
        Rst_n = 1'b1;
        step(1);
        issue(6'd8, 6'd0, 5'd0, 5'd1, 5'd0, 16'hFFFF, 32'd5, 32'd0);
        check("addi_ctl", alu_ctl, 6'b100000);
        check("addi_b", alu_b, 32'hFFFFFFFF);
        step(1);
        check("addi_valid", out_valid, 1);
        check("addi_result", out_result, 32'd4);
        issue(6'd0, 6'd42, 5'd0, 5'd2, 5'd0, 16'h0, 32'h80000000, 32'h1);
        check("slt_ctl", alu_ctl, 6'b100010);
        step(1);
        check("slt_neg", out_result, 32'd1);
        issue(6'd0, 6'd42, 5'd0, 5'd2, 5'd0, 16'h0, 32'h1, 32'h80000000);
        step(1);
        check("slt_pos", out_result, 32'd0);
        issue(6'd0, 6'd0, 5'd0, 5'd3, 5'd31, 16'h0, 32'hDEAD, 32'h1);
        check("sll_a", alu_a, 32'd1);
        check("sll_b", alu_b, 32'd31);
        step(1);
        check("sll_result", out_result, 32'h80000000);
        issue(6'd13, 6'd0, 5'd0, 5'd4, 5'd0, 16'h8000, 32'h1, 32'h0);
        check("ori_zext", alu_b, 32'h00008000);
        step(1);
        check("ori_result", out_result, 32'h00008001);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 3; i++) begin
                issue(bop[k], 6'd0, brt[k], 5'd5, 5'd0, 16'h0, rsv[i], 32'h0);
                step(1);
                check($sformatf("branch_%0d_%0d", k, i), out_br_taken, tk[k][2-i]);
            end
        issue(6'h3F, 6'd0, 5'd0, 5'd6, 5'd0, 16'h1234, 32'h55, 32'h66);
        step(1);
        check("illegal_flag", out_illegal, 1);
        check("illegal_result", out_result, 32'd0);
        issue(6'd0, 6'd32, 5'd0, 5'd1, 5'd0, 16'h0, 32'd7, 32'd9);
        issue(6'd0, 6'd34, 5'd0, 5'd2, 5'd0, 16'h0, 32'd3, 32'd5);
        issue(6'd0, 6'd36, 5'd0, 5'd3, 5'd0, 16'h0, 32'hF0F0FFFF, 32'h0FF00F0F);
        issue(6'd0, 6'd37, 5'd0, 5'd4, 5'd0, 16'h0, 32'hF0F00000, 32'h0000000F);
        issue(6'd0, 6'd39, 5'd0, 5'd5, 5'd0, 16'h0, 32'hF0F00000, 32'h0000000F);
        issue(6'd0, 6'd38, 5'd0, 5'd6, 5'd0, 16'h0, 32'hFFFF0000, 32'h0F0F0F0F);
        issue(6'd0, 6'd2, 5'd0, 5'd7, 5'd4, 16'h0, 32'h0, 32'hF0000000);
        issue(6'd28, 6'd2, 5'd0, 5'd8, 5'd0, 16'h0, 32'h00010001, 32'h00010001);
        issue(6'd35, 6'd0, 5'd0, 5'd9, 5'd0, 16'hFFFC, 32'd100, 32'h0);
        issue(6'd43, 6'd0, 5'd0, 5'd10, 5'd0, 16'h0010, 32'd100, 32'h0);
        issue(6'd32, 6'd0, 5'd0, 5'd11, 5'd0, 16'h8000, 32'h0, 32'h0);
        issue(6'd33, 6'd0, 5'd0, 5'd12, 5'd0, 16'h7FFF, 32'h1, 32'h0);
        issue(6'd40, 6'd0, 5'd0, 5'd13, 5'd0, 16'h0001, 32'hFFFFFFFF, 32'h0);
        issue(6'd41, 6'd0, 5'd0, 5'd14, 5'd0, 16'h0002, 32'h10, 32'h0);
        issue(6'd10, 6'd0, 5'd0, 5'd15, 5'd0, 16'hFFFF, 32'hFFFFFFFE, 32'h0);
        issue(6'd12, 6'd0, 5'd0, 5'd16, 5'd0, 16'h8F0F, 32'hFFFFFFFF, 32'h0);
        issue(6'd14, 6'd0, 5'd0, 5'd17, 5'd0, 16'hFFFF, 32'h12345678, 32'h0);
        issue(6'd4, 6'd0, 5'd0, 5'd18, 5'd0, 16'h0, 32'd42, 32'd42);
        issue(6'd5, 6'd0, 5'd0, 5'd19, 5'd0, 16'h0, 32'd42, 32'd42);
        issue(6'd1, 6'd0, 5'd2, 5'd20, 5'd0, 16'h0, 32'd1, 32'd0);
        issue(6'd0, 6'd8, 5'd0, 5'd21, 5'd0, 16'h0, 32'd1, 32'd2);
        issue(6'd28, 6'd0, 5'd0, 5'd22, 5'd0, 16'h0, 32'd1, 32'd2);
        step(3);
        out_ready = 1'b0;
        fork
            begin
                issue(6'd8, 6'd0, 5'd0, 5'd23, 5'd0, 16'd1, 32'd10, 32'd0);
                issue(6'd8, 6'd0, 5'd0, 5'd24, 5'd0, 16'd2, 32'd10, 32'd0);
                issue(6'd0, 6'd34, 5'd0, 5'd25, 5'd0, 16'd0, 32'd10, 32'd3);
                issue(6'd0, 6'd0, 5'd0, 5'd26, 5'd8, 16'd0, 32'd0, 32'h00FF00FF);
            end
            begin
                step(3);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_out_rd", out_rd, 5'd23);
                out_ready = 1'b1;
            end
        join
        step(4);
        issue(6'd8, 6'd0, 5'd0, 5'd27, 5'd0, 16'd5, 32'd10, 32'd0);
        in_opcode = 6'd8; in_rd = 5'd28; in_valid = 1'b1; flush = 1'b1;
        @(negedge Clk);
        check("flush_in_ready", in_ready, 1);
        step(1);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_kill_0", out_valid, 0);
        step(1);
        check("flush_kill_1", out_valid, 0);
        out_ready = 1'b0;
        issue(6'd8, 6'd0, 5'd0, 5'd29, 5'd0, 16'd1, 32'd1, 32'd0);
        issue(6'd8, 6'd0, 5'd0, 5'd30, 5'd0, 16'd2, 32'd1, 32'd0);
        check("pre_reset_valid", out_valid, 1);
        Rst_n = 1'b0;
        #1;
        check("midrst_outputs", {out_valid, out_br_taken, out_illegal, out_rd, alu_ctl}, 32'd0);
        check("midrst_data", out_result | alu_a | alu_b, 32'd0);
        check("midrst_in_ready", in_ready, 1);
        step(1);
        Rst_n = 1'b1;
        out_ready = 1'b1;
        step(2);
        check("post_reset_idle", out_valid, 0);
        issue(6'd8, 6'd0, 5'd0, 5'd31, 5'd0, 16'h0003, 32'd4, 32'd0);
        step(1);
        check("post_reset_result", out_result, 32'd7);
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
